ahblite_decoder_mux: RTL and testbench
======================================

AHBLITE_DECODER_MUX -- requirements
Module: ahblite_decoder_mux

Interface
REQ-001 Parameter NUM_SLAVES, default 4: number of AHB-Lite slave ports, legal range 1..8.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter DATA_W, default 32: data width, 32 or 64.
REQ-004 Parameter SLV_BASE, default 0: packed NUM_SLAVES x ADDR_W region base addresses.
REQ-005 Parameter SLV_MASK, default 0: packed NUM_SLAVES x ADDR_W region compare masks.
REQ-006 Parameter TIMEOUT_CYC, default 1024: wait-state watchdog limit; 0 disables the watchdog.
REQ-007 One clock; reset is asynchronous and active-low. Ports are HCLK and HRESETN.
REQ-008 HCLK  in  1  bus clock.
REQ-009 HRESETN  in  1  asynchronous active-low reset.
REQ-010 HSEL_M, HWRITE_M, HMASTLOCK_M  in  1 each  master address-phase controls.
REQ-011 HADDR_M  in  ADDR_W; HTRANS_M  in  2; HSIZE_M  in  3; HBURST_M  in  3; HPROT_M  in  4; HWDATA_M  in  DATA_W: master address-phase and write-data signals.
REQ-012 HREADY_M  out  1; HRESP_M  out  1; HRDATA_M  out  DATA_W: muxed response to the master.
REQ-013 HSEL_S  out  NUM_SLAVES: per-slave select.
REQ-014 HADDR_S, HTRANS_S, HWRITE_S, HSIZE_S, HBURST_S, HPROT_S, HWDATA_S, HMASTLOCK_S  out  (master widths): broadcast copies of the master signals.
REQ-015 HREADY_S  out  1: broadcast of HREADY_M.
REQ-016 HREADYOUT_S  in  NUM_SLAVES; HRESP_S  in  NUM_SLAVES; HRDATA_S  in  NUM_SLAVES x DATA_W: per-slave responses.
REQ-017 TIMEOUT_IRQ  out  1: sticky watchdog flag.
REQ-018 TIMEOUT_SLV  out  4: index of the stalling target; 15 denotes the default slave.
REQ-019 TIMEOUT_CLR  in  1: single-cycle clear of TIMEOUT_IRQ.

Function
REQ-020 Slave i matches when (HADDR_M & SLV_MASK[i]) == SLV_BASE[i]; on overlapping matches the lowest index wins; the decode is combinational.
REQ-021 HSEL_S[i] = HSEL_M & match_i & ~match_j for all j < i.
REQ-022 The data-phase selector register loads on every HCLK edge where HREADY_M=1, with one of: slave index, DEFAULT (HSEL_M=1 and no match), or NONE (HSEL_M=0).
REQ-023 For a slave selector, HREADY_M, HRESP_M and HRDATA_M equal that slave's HREADYOUT/HRESP/HRDATA, with zero added latency.
REQ-024 For a NONE selector: HREADY_M=1, HRESP_M=0, HRDATA_M=0.
REQ-025 Default slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2:
- DS_IDLE -> DS_ERR1 when an unmapped NONSEQ/SEQ is accepted (HREADY_M=1).
- DS_ERR1 outputs HREADY=0, HRESP=1, then goes to DS_ERR2.
- DS_ERR2 outputs HREADY=1, HRESP=1, then goes to DS_IDLE, or to DS_ERR1 if another unmapped NONSEQ/SEQ is accepted in the same cycle.
REQ-026 An unmapped IDLE or BUSY gives a zero-wait OKAY response.
REQ-027 Default-slave HRDATA is 0.
REQ-028 Watchdog counter:
- Increments each cycle with HREADY_M=0 and resets to 0 when HREADY_M=1.
- Saturates at TIMEOUT_CYC.
- On reaching TIMEOUT_CYC, sets TIMEOUT_IRQ and captures TIMEOUT_SLV once per stall.
REQ-029 TIMEOUT_CLR clears TIMEOUT_IRQ; if set and clear occur in the same cycle, set wins.
REQ-030 The watchdog never alters bus signalling; the stalled slave keeps ownership of the data phase.
REQ-031 When TIMEOUT_CYC=0, TIMEOUT_IRQ stays 0 and the counter logic is removed.

Reset
REQ-032 On HRESETN low, asynchronously:
- selector=NONE; FSM=DS_IDLE; counter=0.
- TIMEOUT_IRQ=0; TIMEOUT_SLV=0.
- Hence HREADY_M=1, HRESP_M=0, HRDATA_M=0.
REQ-033 Reset asserted mid-transfer abandons the data phase; the first post-reset cycle presents NONE response values.
REQ-034 Reset deassertion is synchronised externally; the block itself adds no synchroniser.

Structure
REQ-035 Shared package ahblite_pkg holds:
- HTRANS encodings (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- HRESP codes (OKAY=0, ERROR=1).
- Selector encodings SEL_NONE, SEL_DEFAULT=15.
- The default-slave state typedef.
REQ-036 The default slave is a sub-module ahblite_default_slave (HCLK, HRESETN, sel, HTRANS, HREADY in; HREADYOUT, HRESP out).
REQ-037 Decode, selector register, response mux and watchdog stay in the parent.

Verification
REQ-038 Bench setup: NUM_SLAVES=3; bases 0x0000_0000, 0x4000_0000, 0x8000_0000; masks 0xF000_0000; TIMEOUT_CYC=8.
REQ-039 Single read to 0x4000_0010, slave1 HRDATA=0xDEADBEEF, zero wait -> HSEL_S=3'b010; HRDATA_M=0xDEADBEEF one cycle after address phase; HRESP_M=0.
REQ-040 NONSEQ to unmapped 0xC000_0000 -> HREADY_M=0/HRESP_M=1 then HREADY_M=1/HRESP_M=1; next NONSEQ to 0x0 completes OKAY.
REQ-041 IDLE to 0xC000_0000 -> zero-wait OKAY; FSM stays in DS_IDLE.
REQ-042 Slave2 holds HREADYOUT=0 for 10 cycles -> TIMEOUT_IRQ rises on the 8th wait cycle; TIMEOUT_SLV=2; TIMEOUT_CLR in the same cycle as the set leaves IRQ=1; a later TIMEOUT_CLR clears it.
REQ-043 Back-to-back unmapped NONSEQ accepted in DS_ERR2 -> immediate re-entry to DS_ERR1 with no OKAY cycle in between.
REQ-044 HRESETN pulled low during a slave1 wait state -> next cycle HREADY_M=1, HRDATA_M=0, TIMEOUT_IRQ=0.

Source files
------------

// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings, data-phase selector codes and default-slave state type.
package ahblite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  // Selector codes 0..NUM_SLAVES-1 name a real slave; the two codes below cannot clash with them.
  localparam int               SEL_W       = 4;
  localparam logic [SEL_W-1:0] SEL_NONE    = 4'd14;
  localparam logic [SEL_W-1:0] SEL_DEFAULT = 4'd15;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_ERR1,
    DS_ERR2
  } ds_state_e;

  function automatic logic trans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahblite_default_slave.sv
// Default slave: answers unmapped active transfers with the two-cycle AHB ERROR response.
module ahblite_default_slave
  import ahblite_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESETN,
  input  logic       sel,
  input  logic [1:0] HTRANS,
  input  logic       HREADY,
  output logic       HREADYOUT,
  output logic       HRESP
);

  ds_state_e state_q;
  ds_state_e state_d;
  logic      accept;

  assign accept = sel && HREADY && trans_active(HTRANS);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) state_q <= DS_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every output gets a default before the case, so no path leaves a latch behind.
  always_comb begin
    state_d   = state_q;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (state_q)
      DS_IDLE: if (accept) state_d = DS_ERR1;
      DS_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_d   = DS_ERR2;
      end
      DS_ERR2: begin
        HRESP   = HRESP_ERROR;
        state_d = accept ? DS_ERR1 : DS_IDLE;
      end
      default: state_d = DS_IDLE;
    endcase
  end

endmodule

// File: rtl/ahblite_decoder_mux.sv
// AHB-Lite address decoder, data-phase response multiplexer and wait-state watchdog.
module ahblite_decoder_mux
  import ahblite_pkg::*;
#(
  parameter int                           NUM_SLAVES  = 4,
  parameter int                           ADDR_W      = 32,
  parameter int                           DATA_W      = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE    = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK    = '0,
  parameter int                           TIMEOUT_CYC = 1024
) (
  input  logic                         HCLK,
  input  logic                         HRESETN,
  input  logic                         HSEL_M,
  input  logic [ADDR_W-1:0]            HADDR_M,
  input  logic [1:0]                   HTRANS_M,
  input  logic                         HWRITE_M,
  input  logic [2:0]                   HSIZE_M,
  input  logic [2:0]                   HBURST_M,
  input  logic [3:0]                   HPROT_M,
  input  logic [DATA_W-1:0]            HWDATA_M,
  input  logic                         HMASTLOCK_M,
  output logic                         HREADY_M,
  output logic                         HRESP_M,
  output logic [DATA_W-1:0]            HRDATA_M,
  output logic [NUM_SLAVES-1:0]        HSEL_S,
  output logic [ADDR_W-1:0]            HADDR_S,
  output logic [1:0]                   HTRANS_S,
  output logic                         HWRITE_S,
  output logic [2:0]                   HSIZE_S,
  output logic [2:0]                   HBURST_S,
  output logic [3:0]                   HPROT_S,
  output logic [DATA_W-1:0]            HWDATA_S,
  output logic                         HMASTLOCK_S,
  output logic                         HREADY_S,
  input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]        HRESP_S,
  input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
  output logic                         TIMEOUT_IRQ,
  output logic [3:0]                   TIMEOUT_SLV,
  input  logic                         TIMEOUT_CLR
);

  logic [NUM_SLAVES-1:0] match;
  logic                  hit;
  logic [SEL_W-1:0]      hit_idx;
  logic [SEL_W-1:0]      sel_q;
  logic [SEL_W-1:0]      sel_d;
  logic                  ds_ready;
  logic                  ds_resp;

  assign HADDR_S     = HADDR_M;
  assign HTRANS_S    = HTRANS_M;
  assign HWRITE_S    = HWRITE_M;
  assign HSIZE_S     = HSIZE_M;
  assign HBURST_S    = HBURST_M;
  assign HPROT_S     = HPROT_M;
  assign HWDATA_S    = HWDATA_M;
  assign HMASTLOCK_S = HMASTLOCK_M;
  assign HREADY_S    = HREADY_M;

  // Lowest matching index wins, so overlapping regions resolve deterministically.
  always_comb begin
    match   = '0;
    HSEL_S  = '0;
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      match[i] = (HADDR_M & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W];
      if (match[i] && !hit) begin
        hit       = 1'b1;
        hit_idx   = SEL_W'(i);
        HSEL_S[i] = HSEL_M;
      end
    end
  end

  assign sel_d = !HSEL_M ? SEL_NONE : (hit ? hit_idx : SEL_DEFAULT);

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN)      sel_q <= SEL_NONE;
    else if (HREADY_M) sel_q <= sel_d;
  end

  ahblite_default_slave u_default_slave (
    .HCLK      (HCLK),
    .HRESETN   (HRESETN),
    .sel       (HSEL_M && !hit),
    .HTRANS    (HTRANS_M),
    .HREADY    (HREADY_M),
    .HREADYOUT (ds_ready),
    .HRESP     (ds_resp)
  );

  // Response path is purely combinational from the registered selector: zero added latency.
  always_comb begin
    HREADY_M = 1'b1;
    HRESP_M  = HRESP_OKAY;
    HRDATA_M = '0;
    if (sel_q == SEL_DEFAULT) begin
      HREADY_M = ds_ready;
      HRESP_M  = ds_resp;
    end else begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (sel_q == SEL_W'(i)) begin
          HREADY_M = HREADYOUT_S[i];
          HRESP_M  = HRESP_S[i];
          HRDATA_M = HRDATA_S[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  generate
    if (TIMEOUT_CYC > 0) begin : g_wdog
      localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
      logic [CNT_W-1:0] cnt_q;
      logic             irq_q;
      logic [3:0]       slv_q;
      logic             set;

      // Fires on the wait cycle that brings the count to the limit; saturation keeps it one-shot.
      assign set = !HREADY_M && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

      always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
          cnt_q <= '0;
          irq_q <= 1'b0;
          slv_q <= '0;
        end else begin
          if (HREADY_M)                         cnt_q <= '0;
          else if (cnt_q != CNT_W'(TIMEOUT_CYC)) cnt_q <= cnt_q + 1'b1;
          if (set)              irq_q <= 1'b1;
          else if (TIMEOUT_CLR) irq_q <= 1'b0;
          if (set)              slv_q <= sel_q;
        end
      end

      assign TIMEOUT_IRQ = irq_q;
      assign TIMEOUT_SLV = slv_q;
    end else begin : g_no_wdog
      assign TIMEOUT_IRQ = 1'b0;
      assign TIMEOUT_SLV = 4'd0;
    end
  endgenerate

endmodule

// File: tb/tb_ahblite_decoder_mux.sv
// Bench for ahblite_decoder_mux: directed scenarios plus randomized traffic against a transaction-level model.
module tb_ahblite_decoder_mux;
  import ahblite_pkg::*;

  localparam int NS = 3;
  localparam int TO = 8;
  localparam logic [31:0] REGION_BASE [3] = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000};
  localparam logic [31:0] REGION_MASK = 32'hF000_0000;
  localparam int OWN_NONE    = -1;
  localparam int OWN_DEFAULT = 15;

  logic        HCLK = 1'b0;
  logic        HRESETN = 1'b0;
  logic        HSEL_M = 1'b0, HWRITE_M = 1'b0, HMASTLOCK_M = 1'b0;
  logic [31:0] HADDR_M = '0, HWDATA_M = '0;
  logic [1:0]  HTRANS_M = '0;
  logic [2:0]  HSIZE_M = '0, HBURST_M = '0;
  logic [3:0]  HPROT_M = '0;
  logic        HREADY_M, HRESP_M;
  logic [31:0] HRDATA_M;
  logic [2:0]  HSEL_S;
  logic [31:0] HADDR_S, HWDATA_S;
  logic [1:0]  HTRANS_S;
  logic        HWRITE_S, HMASTLOCK_S, HREADY_S;
  logic [2:0]  HSIZE_S, HBURST_S;
  logic [3:0]  HPROT_S;
  logic [2:0]  HREADYOUT_S = 3'b111, HRESP_S = 3'b000;
  logic [95:0] HRDATA_S = '0;
  logic        TIMEOUT_IRQ, TIMEOUT_CLR = 1'b0;
  logic [3:0]  TIMEOUT_SLV;

  int n_cmp = 0;
  int n_mis = 0;

  // Transaction-level model: who owns the data phase, pending default-slave error beats, stall length.
  int       owner = OWN_NONE;
  bit [1:0] ds_q[$];
  int       stall = 0;
  bit       m_irq = 1'b0;
  bit [3:0] m_tslv = '0;

  ahblite_decoder_mux #(
    .NUM_SLAVES (NS),
    .ADDR_W     (32),
    .DATA_W     (32),
    .SLV_BASE   ({32'h8000_0000, 32'h4000_0000, 32'h0000_0000}),
    .SLV_MASK   ({3{32'hF000_0000}}),
    .TIMEOUT_CYC(TO)
  ) dut (
    .HCLK(HCLK), .HRESETN(HRESETN),
    .HSEL_M(HSEL_M), .HADDR_M(HADDR_M), .HTRANS_M(HTRANS_M), .HWRITE_M(HWRITE_M),
    .HSIZE_M(HSIZE_M), .HBURST_M(HBURST_M), .HPROT_M(HPROT_M), .HWDATA_M(HWDATA_M),
    .HMASTLOCK_M(HMASTLOCK_M),
    .HREADY_M(HREADY_M), .HRESP_M(HRESP_M), .HRDATA_M(HRDATA_M),
    .HSEL_S(HSEL_S), .HADDR_S(HADDR_S), .HTRANS_S(HTRANS_S), .HWRITE_S(HWRITE_S),
    .HSIZE_S(HSIZE_S), .HBURST_S(HBURST_S), .HPROT_S(HPROT_S), .HWDATA_S(HWDATA_S),
    .HMASTLOCK_S(HMASTLOCK_S), .HREADY_S(HREADY_S),
    .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S), .HRDATA_S(HRDATA_S),
    .TIMEOUT_IRQ(TIMEOUT_IRQ), .TIMEOUT_SLV(TIMEOUT_SLV), .TIMEOUT_CLR(TIMEOUT_CLR)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & REGION_MASK) == REGION_BASE[i]) return i;
    return -1;
  endfunction

  function automatic logic [2:0] exp_hsel();
    logic [2:0] hs;
    int d;
    hs = '0;
    d  = ref_decode(HADDR_M);
    if (HSEL_M && d >= 0) hs[d] = 1'b1;
    return hs;
  endfunction

  function automatic logic exp_ready();
    if (owner == OWN_DEFAULT) return (ds_q.size() > 0) ? ds_q[0][1] : 1'b1;
    if (owner >= 0) return HREADYOUT_S[owner];
    return 1'b1;
  endfunction

  function automatic logic exp_resp();
    if (owner == OWN_DEFAULT) return (ds_q.size() > 0) ? ds_q[0][0] : 1'b0;
    if (owner >= 0) return HRESP_S[owner];
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_rdata();
    if (owner >= 0 && owner < NS) return HRDATA_S[owner*32 +: 32];
    return 32'h0;
  endfunction

  task automatic reset_model();
    owner = OWN_NONE;
    ds_q.delete();
    stall  = 0;
    m_irq  = 1'b0;
    m_tslv = '0;
  endtask

  // Apply the bus rules for the edge about to happen, then cross it.
  task automatic advance();
    bit       r;
    bit       set;
    bit [1:0] dummy;
    int       d;
    r   = exp_ready();
    d   = ref_decode(HADDR_M);
    set = 1'b0;
    if (r) stall = 0;
    else begin
      stall++;
      if (stall == TO) begin
        set    = 1'b1;
        m_tslv = 4'(owner);
      end
    end
    if (set) m_irq = 1'b1;
    else if (TIMEOUT_CLR) m_irq = 1'b0;
    if (owner == OWN_DEFAULT && ds_q.size() > 0) dummy = ds_q.pop_front();
    if (r) begin
      if (!HSEL_M) owner = OWN_NONE;
      else if (d >= 0) owner = d;
      else begin
        owner = OWN_DEFAULT;
        if (HTRANS_M >= 2'd2) begin
          ds_q.push_back(2'b01);
          ds_q.push_back(2'b11);
        end
      end
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic sel, input logic [1:0] trans, input logic [31:0] addr);
    HSEL_M   = sel;
    HTRANS_M = trans;
    HADDR_M  = addr;
  endtask

  task automatic set_slave(input int i, input logic rdy, input logic rsp, input logic [31:0] data);
    HREADYOUT_S[i]       = rdy;
    HRESP_S[i]           = rsp;
    HRDATA_S[i*32 +: 32] = data;
  endtask

  task automatic all_slaves_ok();
    for (int i = 0; i < NS; i++) set_slave(i, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    all_slaves_ok();
    drive(1'b1, HTRANS_NONSEQ, 32'h4000_0000);
    @(negedge HCLK);
    n_cmp++;
    if ({HREADY_M, HRESP_M, HRDATA_M} !== {1'b1, 1'b0, 32'h0}) begin
      n_mis++;
      $display("FAIL reset_resp: got %b/%b/%h want 1/0/00000000", HREADY_M, HRESP_M, HRDATA_M);
    end
    n_cmp++;
    if ({TIMEOUT_IRQ, TIMEOUT_SLV} !== 5'b0) begin
      n_mis++;
      $display("FAIL reset_wdog: got irq=%b slv=%0d want irq=0 slv=0", TIMEOUT_IRQ, TIMEOUT_SLV);
    end
    @(posedge HCLK);
    #1;
    HRESETN = 1'b1;
    drive(1'b0, HTRANS_IDLE, 32'h0);
    reset_model();
  endtask

  task automatic test_single_read();
    all_slaves_ok();
    set_slave(1, 1'b1, 1'b0, 32'hDEAD_BEEF);
    drive(1'b1, HTRANS_NONSEQ, 32'h4000_0010);
    HWRITE_M = 1'b0;
    @(negedge HCLK);
    n_cmp++;
    if (HSEL_S !== 3'b010) begin
      n_mis++;
      $display("FAIL read_hsel: got %b want 010", HSEL_S);
    end
    n_cmp++;
    if ({HADDR_S, HTRANS_S, HWRITE_S, HREADY_S} !== {32'h4000_0010, 2'b10, 1'b0, 1'b1}) begin
      n_mis++;
      $display("FAIL read_bcast: got addr=%h trans=%b wr=%b rdy=%b", HADDR_S, HTRANS_S, HWRITE_S, HREADY_S);
    end
    advance();
    drive(1'b0, HTRANS_IDLE, 32'h0);
    @(negedge HCLK);
    n_cmp++;
    if ({HREADY_M, HRESP_M, HRDATA_M} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      n_mis++;
      $display("FAIL read_data: got %b/%b/%h want 1/0/deadbeef", HREADY_M, HRESP_M, HRDATA_M);
    end
    advance();
  endtask

  task automatic test_unmapped();
    all_slaves_ok();
    set_slave(0, 1'b1, 1'b0, 32'hA5A5_0000);
    drive(1'b1, HTRANS_NONSEQ, 32'hC000_0000);
    @(negedge HCLK);
    n_cmp++;
    if (HSEL_S !== 3'b000) begin
      n_mis++;
      $display("FAIL unmapped_hsel: got %b want 000", HSEL_S);
    end
    advance();
    drive(1'b1, HTRANS_IDLE, 32'hC000_0000);
    @(negedge HCLK);
    n_cmp++;
    if ({HREADY_M, HRESP_M} !== 2'b01) begin
      n_mis++;
      $display("FAIL unmapped_err1: got rdy=%b resp=%b want 0/1", HREADY_M, HRESP_M);
    end
    advance();
    drive(1'b1, HTRANS_NONSEQ, 32'h0000_0000);
    @(negedge HCLK);
    n_cmp++;
    if ({HREADY_M, HRESP_M, HSEL_S} !== {2'b11, 3'b001}) begin
      n_mis++;
      $display("FAIL unmapped_err2: got rdy=%b resp=%b hsel=%b want 1/1/001", HREADY_M, HRESP_M, HSEL_S);
    end
    advance();
    drive(1'b0, HTRANS_IDLE, 32'h0);
    @(negedge HCLK);
    n_cmp++;
    if ({HREADY_M, HRESP_M, HRDATA_M} !== {1'b1, 1'b0, 32'hA5A5_0000}) begin
      n_mis++;
      $display("FAIL unmapped_next_okay: got %b/%b/%h want 1/0/a5a50000", HREADY_M, HRESP_M, HRDATA_M);
    end
    advance();
  endtask

  task automatic test_unmapped_idle();
    logic [1:0] kinds [2];
    kinds = '{HTRANS_IDLE, HTRANS_BUSY};
    all_slaves_ok();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, kinds[k], 32'hC000_0000);
      advance();
      drive(1'b0, HTRANS_IDLE, 32'h0);
      @(negedge HCLK);
      n_cmp++;
      if ({HREADY_M, HRESP_M, HRDATA_M} !== {1'b1, 1'b0, 32'h0}) begin
        n_mis++;
        $display("FAIL unmapped_idle_%0d: got %b/%b/%h want 1/0/00000000", k, HREADY_M, HRESP_M, HRDATA_M);
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] want [5];
    want = '{2'b01, 2'b11, 2'b01, 2'b11, 2'b10};
    all_slaves_ok();
    drive(1'b1, HTRANS_NONSEQ, 32'hC000_0000);
    advance();
    for (int c = 0; c < 5; c++) begin
      if (c < 2) drive(1'b1, HTRANS_NONSEQ, 32'hC000_0004);
      else       drive(1'b0, HTRANS_IDLE, 32'h0);
      @(negedge HCLK);
      n_cmp++;
      if ({HREADY_M, HRESP_M} !== want[c]) begin
        n_mis++;
        $display("FAIL b2b_cycle%0d: got rdy=%b resp=%b want %b", c, HREADY_M, HRESP_M, want[c]);
      end
      advance();
    end
  endtask

  task automatic test_timeout();
    all_slaves_ok();
    set_slave(2, 1'b0, 1'b0, 32'h2222_2222);
    drive(1'b1, HTRANS_NONSEQ, 32'h8000_0000);
    advance();
    drive(1'b1, HTRANS_IDLE, 32'h0);
    for (int w = 1; w <= 10; w++) begin
      TIMEOUT_CLR = (w == TO);
      @(negedge HCLK);
      n_cmp++;
      if ({HREADY_M, TIMEOUT_IRQ} !== {1'b0, (w > TO) ? 1'b1 : 1'b0}) begin
        n_mis++;
        $display("FAIL timeout_wait%0d: got rdy=%b irq=%b want rdy=0 irq=%b", w, HREADY_M, TIMEOUT_IRQ, w > TO);
      end
      if (w > TO) begin
        n_cmp++;
        if (TIMEOUT_SLV !== 4'd2) begin
          n_mis++;
          $display("FAIL timeout_slv: got %0d want 2", TIMEOUT_SLV);
        end
      end
      advance();
    end
    TIMEOUT_CLR = 1'b0;
    set_slave(2, 1'b1, 1'b0, 32'h2222_2222);
    @(negedge HCLK);
    n_cmp++;
    if ({HREADY_M, HRDATA_M, TIMEOUT_IRQ} !== {1'b1, 32'h2222_2222, 1'b1}) begin
      n_mis++;
      $display("FAIL timeout_release: got rdy=%b data=%h irq=%b want 1/22222222/1", HREADY_M, HRDATA_M, TIMEOUT_IRQ);
    end
    advance();
    drive(1'b0, HTRANS_IDLE, 32'h0);
    TIMEOUT_CLR = 1'b1;
    advance();
    TIMEOUT_CLR = 1'b0;
    @(negedge HCLK);
    n_cmp++;
    if (TIMEOUT_IRQ !== 1'b0) begin
      n_mis++;
      $display("FAIL timeout_clear: got irq=%b want 0", TIMEOUT_IRQ);
    end
    advance();
  endtask

  task automatic test_random(input int cycles);
    logic [3:0] nib;
    logic [2:0] stuck;
    stuck = '0;
    for (int c = 0; c < cycles; c++) begin
      nib = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3) * 4);
      drive(($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)), {nib, 28'($urandom)});
      HWRITE_M    = 1'($urandom);
      HSIZE_M     = 3'($urandom);
      HBURST_M    = 3'($urandom);
      HPROT_M     = 4'($urandom);
      HWDATA_M    = $urandom;
      HMASTLOCK_M = 1'($urandom);
      if ($urandom_range(0, 31) == 0) stuck = 3'($urandom);
      for (int i = 0; i < NS; i++)
        set_slave(i, !stuck[i] && ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), $urandom);
      TIMEOUT_CLR = ($urandom_range(0, 15) == 0);
      @(negedge HCLK);
      n_cmp++;
      if ({HREADY_M, HRESP_M, HRDATA_M} !== {exp_ready(), exp_resp(), exp_rdata()}) begin
        n_mis++;
        $display("FAIL rand_resp c%0d: got %b/%b/%h want %b/%b/%h",
                 c, HREADY_M, HRESP_M, HRDATA_M, exp_ready(), exp_resp(), exp_rdata());
      end
      n_cmp++;
      if ({HSEL_S, HREADY_S} !== {exp_hsel(), exp_ready()}) begin
        n_mis++;
        $display("FAIL rand_hsel c%0d: got %b/%b want %b/%b", c, HSEL_S, HREADY_S, exp_hsel(), exp_ready());
      end
      n_cmp++;
      if ({HADDR_S, HTRANS_S, HWRITE_S, HSIZE_S, HBURST_S, HPROT_S, HWDATA_S, HMASTLOCK_S} !==
          {HADDR_M, HTRANS_M, HWRITE_M, HSIZE_M, HBURST_M, HPROT_M, HWDATA_M, HMASTLOCK_M}) begin
        n_mis++;
        $display("FAIL rand_bcast c%0d: got addr=%h trans=%b want addr=%h trans=%b", c, HADDR_S, HTRANS_S, HADDR_M, HTRANS_M);
      end
      n_cmp++;
      if ({TIMEOUT_IRQ, TIMEOUT_SLV} !== {m_irq, m_tslv}) begin
        n_mis++;
        $display("FAIL rand_wdog c%0d: got irq=%b slv=%0d want irq=%b slv=%0d", c, TIMEOUT_IRQ, TIMEOUT_SLV, m_irq, m_tslv);
      end
      advance();
    end
    TIMEOUT_CLR = 1'b0;
  endtask

  task automatic test_reset_mid();
    all_slaves_ok();
    set_slave(1, 1'b0, 1'b0, 32'h1234_5678);
    drive(1'b1, HTRANS_NONSEQ, 32'h4000_0000);
    advance();
    drive(1'b0, HTRANS_IDLE, 32'h0);
    for (int w = 0; w < TO + 1; w++) advance();
    @(negedge HCLK);
    n_cmp++;
    if ({HREADY_M, TIMEOUT_IRQ, TIMEOUT_SLV} !== {1'b0, 1'b1, 4'd1}) begin
      n_mis++;
      $display("FAIL rstmid_pre: got rdy=%b irq=%b slv=%0d want 0/1/1", HREADY_M, TIMEOUT_IRQ, TIMEOUT_SLV);
    end
    #1;
    HRESETN = 1'b0;
    #1;
    n_cmp++;
    if ({HREADY_M, HRESP_M, HRDATA_M, TIMEOUT_IRQ} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      n_mis++;
      $display("FAIL rstmid_async: got %b/%b/%h irq=%b want 1/0/00000000 irq=0", HREADY_M, HRESP_M, HRDATA_M, TIMEOUT_IRQ);
    end
    reset_model();
    @(posedge HCLK);
    #1;
    HRESETN = 1'b1;
    @(negedge HCLK);
    n_cmp++;
    if ({HREADY_M, HRDATA_M, TIMEOUT_IRQ} !== {1'b1, 32'h0, 1'b0}) begin
      n_mis++;
      $display("FAIL rstmid_after: got rdy=%b data=%h irq=%b want 1/00000000/0", HREADY_M, HRDATA_M, TIMEOUT_IRQ);
    end
    advance();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_unmapped();
    test_unmapped_idle();
    test_back_to_back();
    test_timeout();
    test_random(500);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
